// File: rtl/net_tx_arbiter_if.sv
// net_tx_arbiter_if
//   Bundles the two requester byte streams, the shared network stream and the
//   arbiter status outputs of net_tx_arbiter.
//   slave  : arbiter view (requester data/valid/last and net_tready_in are inputs)
//   master : environment view (drives requesters and net_tready_in, observes the rest)
//   Signals:
//     arp_tdata_in[7:0], arp_tvalid_in, arp_tlast_in, arp_tready_out  requester 0
//     ip_tdata_in[7:0],  ip_tvalid_in,  ip_tlast_in,  ip_tready_out   requester 1
//     net_tdata_out[7:0], net_tvalid_out, net_tlast_out, net_tready_in shared stream
//     arb_grant_out[1:0]  one-hot owner (bit0 ARP, bit1 IP)
//     arb_busy_out        arbiter not idle
//     arp_frame_cnt_out, ip_frame_cnt_out [15:0]  completed frames
interface net_tx_arbiter_if;
  logic [7:0]  arp_tdata_in;
  logic        arp_tvalid_in;
  logic        arp_tlast_in;
  logic        arp_tready_out;
  logic [7:0]  ip_tdata_in;
  logic        ip_tvalid_in;
  logic        ip_tlast_in;
  logic        ip_tready_out;
  logic [7:0]  net_tdata_out;
  logic        net_tvalid_out;
  logic        net_tlast_out;
  logic        net_tready_in;
  logic [1:0]  arb_grant_out;
  logic        arb_busy_out;
  logic [15:0] arp_frame_cnt_out;
  logic [15:0] ip_frame_cnt_out;

  modport slave (
    input  arp_tdata_in, arp_tvalid_in, arp_tlast_in,
    input  ip_tdata_in, ip_tvalid_in, ip_tlast_in,
    input  net_tready_in,
    output arp_tready_out, ip_tready_out,
    output net_tdata_out, net_tvalid_out, net_tlast_out,
    output arb_grant_out, arb_busy_out,
    output arp_frame_cnt_out, ip_frame_cnt_out
  );

  modport master (
    output arp_tdata_in, arp_tvalid_in, arp_tlast_in,
    output ip_tdata_in, ip_tvalid_in, ip_tlast_in,
    output net_tready_in,
    input  arp_tready_out, ip_tready_out,
    input  net_tdata_out, net_tvalid_out, net_tlast_out,
    input  arb_grant_out, arb_busy_out,
    input  arp_frame_cnt_out, ip_frame_cnt_out
  );
endinterface

// File: rtl/net_tx_arbiter.sv
// net_tx_arbiter
//   Two-requester (ARP, IP) frame arbiter onto one network byte stream.
//   The grant is taken in IDLE and held for a whole frame; frame end is a
//   granted beat with tlast accepted by the network side.
//   Parameters:
//     PRIORITY_MODE  0 = round-robin on ties, 1 = ARP always wins ties
//     IFG_CYCLES     inter-frame gap length (1..255), used with NET_TX_IFG_EN
//   Ports:
//     logic_clk  rising-edge clock
//     logic_rst  asynchronous active-high reset
//     bus        net_tx_arbiter_if.slave (streams, grant, busy, frame counters)
//   Build option:
//     NET_TX_IFG_EN  when defined, every frame is followed by IFG_CYCLES idle
//                    cycles in GAP; otherwise frame end returns straight to IDLE.
//
//   state | meaning
//   IDLE  | no owner, pick a requester when any tvalid is high
//   XFER  | granted requester is connected to the network stream
//   GAP   | inter-frame gap, outputs held at 0 (NET_TX_IFG_EN only)
module net_tx_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int IFG_CYCLES    = 12
) (
  input logic           logic_clk,
  input logic           logic_rst,
  net_tx_arbiter_if.slave bus
);

  if (IFG_CYCLES < 1 || IFG_CYCLES > 255) begin : g_bad_ifg
    $error("IFG_CYCLES must be in 1..255");
  end

`ifdef NET_TX_IFG_EN
  typedef enum logic [1:0] {IDLE, XFER, GAP} state_e;
  localparam logic [7:0] GapLoad = 8'(IFG_CYCLES);
  logic [7:0] gap_cnt_q, gap_cnt_d;
`else
  typedef enum logic [1:0] {IDLE, XFER} state_e;
`endif

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_ip_q, last_ip_d;   // 1 = IP was granted most recently
  logic [15:0] arp_cnt_q, arp_cnt_d;
  logic [15:0] ip_cnt_q, ip_cnt_d;

  logic        in_xfer;
  logic        sel_valid;
  logic        sel_last;
  logic [7:0]  sel_data;
  logic        frame_end;
  logic        pick_arp;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    if (grant_q[0]) begin
      sel_valid = bus.arp_tvalid_in;
      sel_last  = bus.arp_tlast_in;
      sel_data  = bus.arp_tdata_in;
    end else if (grant_q[1]) begin
      sel_valid = bus.ip_tvalid_in;
      sel_last  = bus.ip_tlast_in;
      sel_data  = bus.ip_tdata_in;
    end
  end

  assign in_xfer   = (state_q == XFER);
  assign frame_end = in_xfer & sel_valid & sel_last & bus.net_tready_in;

  // On a tie, round-robin hands the stream to whoever was not served last.
  always_comb begin
    if (PRIORITY_MODE == 1) pick_arp = bus.arp_tvalid_in;
    else                    pick_arp = bus.arp_tvalid_in & (~bus.ip_tvalid_in | last_ip_q);
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_ip_d = last_ip_q;
    arp_cnt_d = arp_cnt_q;
    ip_cnt_d  = ip_cnt_q;
`ifdef NET_TX_IFG_EN
    gap_cnt_d = gap_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.arp_tvalid_in | bus.ip_tvalid_in) begin
          state_d   = XFER;
          grant_d   = pick_arp ? 2'b01 : 2'b10;
          last_ip_d = ~pick_arp;
        end
      end
      XFER: begin
        if (frame_end) begin
          grant_d = 2'b00;
          if (grant_q[0]) arp_cnt_d = arp_cnt_q + 16'd1;
          else            ip_cnt_d  = ip_cnt_q + 16'd1;
`ifdef NET_TX_IFG_EN
          state_d   = GAP;
          gap_cnt_d = GapLoad;
`else
          state_d   = IDLE;
`endif
        end
      end
`ifdef NET_TX_IFG_EN
      GAP: begin
        gap_cnt_d = gap_cnt_q - 8'd1;
        if (gap_cnt_q == 8'd1) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      last_ip_q <= 1'b1;
      arp_cnt_q <= 16'h0000;
      ip_cnt_q  <= 16'h0000;
`ifdef NET_TX_IFG_EN
      gap_cnt_q <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_ip_q <= last_ip_d;
      arp_cnt_q <= arp_cnt_d;
      ip_cnt_q  <= ip_cnt_d;
`ifdef NET_TX_IFG_EN
      gap_cnt_q <= gap_cnt_d;
`endif
    end
  end

  assign bus.net_tvalid_out    = in_xfer & sel_valid;
  assign bus.net_tlast_out     = in_xfer & sel_last;
  assign bus.net_tdata_out     = in_xfer ? sel_data : 8'h00;
  assign bus.arp_tready_out    = in_xfer & grant_q[0] & bus.net_tready_in;
  assign bus.ip_tready_out     = in_xfer & grant_q[1] & bus.net_tready_in;
  assign bus.arb_grant_out     = grant_q;
  assign bus.arb_busy_out      = (state_q != IDLE);
  assign bus.arp_frame_cnt_out = arp_cnt_q;
  assign bus.ip_frame_cnt_out  = ip_cnt_q;

endmodule
